// File: rtl/pluto_profile_sweeper_pkg.sv
// Shared types for the Pluto profile sweeper: sweep modes, FSM states and the
// helper that places a profile index onto the AD936x control pins.
package pluto_profile_sweeper_pkg;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Callers truncate the result to their own gpio width.
  function automatic logic [31:0] gpioMap(input logic [31:0] profile, input int unsigned shift);
    return profile << shift;
  endfunction

endpackage

// File: rtl/pluto_profile_sweeper_dwell_timer.sv
// Loadable dwell down-counter: expires when it reaches zero while enabled and
// then reloads itself from i_value so the next step gets the same dwell.
module pluto_profile_sweeper_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_value,
  input  logic               i_enable,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_enable) begin
      r_count <= (r_count == '0) ? i_value : r_count - DWELL_W'(1);
    end
  end

  assign o_expire = i_enable && !i_load && (r_count == '0);

endmodule

// File: rtl/pluto_profile_sweeper.sv
// Steps an AD936x profile index across [first..last] with a programmable dwell,
// in free-run, triangle or single-shot mode, and strobes step/sweep-start/done.
module pluto_profile_sweeper
  import pluto_profile_sweeper_pkg::*;
#(
  parameter int PROF_W     = 3,
  parameter int GPIO_W     = 14,
  parameter int GPIO_SHIFT = 9,
  parameter int DWELL_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PROF_W-1:0]  first_profile,
  input  logic [PROF_W-1:0]  last_profile,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               abort,
  output logic [PROF_W-1:0]  profile_o,
  output logic [GPIO_W-1:0]  gpio_o,
  output logic               step_o,
  output logic               sweep_start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  state_e              r_state;
  mode_e               r_mode;
  logic [PROF_W-1:0]   r_first;
  logic [PROF_W-1:0]   r_last;
  logic [DWELL_W-1:0]  r_dwell;
  logic [PROF_W-1:0]   r_profile;
  logic [GPIO_W-1:0]   r_gpio;
  logic                r_dirUp;
  logic                r_err;
  logic                r_step;
  logic                r_sweep;
  logic                r_done;

  state_e              w_stateNext;
  logic [PROF_W-1:0]   w_profileNext;
  logic                w_dirUpNext;
  logic                w_errNext;
  logic                w_stepNext;
  logic                w_sweepNext;
  logic                w_doneNext;
  logic                w_validStart;
  logic                w_load;
  logic                w_expire;
  logic [DWELL_W-1:0]  w_timerValue;

  assign w_validStart = start && (first_profile <= last_profile);
  assign w_load       = w_validStart && !abort;
  assign w_timerValue = w_validStart ? dwell : r_dwell;

  pluto_profile_sweeper_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwellTimer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_value  (w_timerValue),
    .i_enable ((r_state == RUN) && enable),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Priority is abort, then a valid start, then the dwell-expiry step.
  always_comb begin
    w_stateNext   = r_state;
    w_profileNext = r_profile;
    w_dirUpNext   = r_dirUp;
    w_errNext     = r_err;
    w_stepNext    = 1'b0;
    w_sweepNext   = 1'b0;
    w_doneNext    = 1'b0;
    if (abort) begin
      w_stateNext = IDLE;
    end else if (w_validStart) begin
      w_stateNext   = RUN;
      w_profileNext = first_profile;
      w_dirUpNext   = 1'b1;
      w_errNext     = 1'b0;
      w_stepNext    = 1'b1;
      w_sweepNext   = 1'b1;
    end else begin
      if (start) begin
        w_errNext = 1'b1;
      end
      if (w_expire) begin
        w_stepNext = 1'b1;
        case (r_mode)
          MODE_SINGLE: begin
            if (r_profile == r_last) begin
              w_stepNext  = 1'b0;
              w_doneNext  = 1'b1;
              w_stateNext = IDLE;
            end else begin
              w_profileNext = r_profile + PROF_W'(1);
            end
          end
          MODE_TRI: begin
            if (r_first == r_last) begin
              w_profileNext = r_first;
            end else if (r_dirUp) begin
              if (r_profile == r_last) begin
                w_profileNext = r_profile - PROF_W'(1);
                w_dirUpNext   = 1'b0;
              end else begin
                w_profileNext = r_profile + PROF_W'(1);
              end
            end else begin
              if (r_profile == r_first) begin
                w_profileNext = r_profile + PROF_W'(1);
                w_dirUpNext   = 1'b1;
              end else begin
                w_profileNext = r_profile - PROF_W'(1);
              end
            end
          end
          default: begin
            w_profileNext = (r_profile == r_last) ? r_first : r_profile + PROF_W'(1);
          end
        endcase
        w_sweepNext = w_stepNext && (w_profileNext == r_first);
      end
    end
  end

  // gpio is derived from the next profile so both outputs change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= MODE_FREE;
      r_first   <= '0;
      r_last    <= '0;
      r_dwell   <= '0;
      r_profile <= '0;
      r_gpio    <= '0;
      r_dirUp   <= 1'b1;
      r_err     <= 1'b0;
      r_step    <= 1'b0;
      r_sweep   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_load) begin
        r_mode  <= mode_e'(mode);
        r_first <= first_profile;
        r_last  <= last_profile;
        r_dwell <= dwell;
      end
      r_profile <= w_profileNext;
      r_gpio    <= GPIO_W'(gpioMap(32'(w_profileNext), GPIO_SHIFT));
      r_dirUp   <= w_dirUpNext;
      r_err     <= w_errNext;
      r_step    <= w_stepNext;
      r_sweep   <= w_sweepNext;
      r_done    <= w_doneNext;
    end
  end

  assign profile_o     = r_profile;
  assign gpio_o        = r_gpio;
  assign step_o        = r_step;
  assign sweep_start_o = r_sweep;
  assign busy_o        = (r_state == RUN);
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule

// File: tb/tb_pluto_profile_sweeper.sv
// Self-checking bench for pluto_profile_sweeper: a sweep-index reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pluto_profile_sweeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [2:0]  firstP;
  logic [2:0]  lastP;
  logic [23:0] dwell;
  logic        start;
  logic        abort;
  logic [2:0]  profile_o;
  logic [13:0] gpio_o;
  logic        step_o;
  logic        sweep_start_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int nChecks = 0;
  int nFails  = 0;

  int mRun = 0, mMode = 0, mFirst = 0, mLast = 0, mDwell = 0;
  int mK = 0, mAge = 0, mN = 0, mProfile = 0, mErr = 0;
  int mStep = 0, mSweep = 0, mDone = 0;

  pluto_profile_sweeper dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .first_profile (firstP),
    .last_profile  (lastP),
    .dwell         (dwell),
    .start         (start),
    .abort         (abort),
    .profile_o     (profile_o),
    .gpio_o        (gpio_o),
    .step_o        (step_o),
    .sweep_start_o (sweep_start_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Profile visited at step k of a sweep, from the mode's index pattern.
  function automatic int profAt(input int md, input int f, input int l, input int k);
    int n, period, m;
    n = l - f + 1;
    if (md == 1) begin
      if (n == 1) return f;
      period = 2 * (n - 1);
      m = k % period;
      return f + ((m < n) ? m : period - m);
    end
    return f + (k % n);
  endfunction

  // Reference model: sweep position k and cycles spent at the current step.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      mStep = 0; mSweep = 0; mDone = 0;
      if (!reset) begin
        mRun = 0; mProfile = 0; mErr = 0; mK = 0; mAge = 0;
      end else if (abort) begin
        mRun = 0;
      end else if (start && firstP <= lastP) begin
        mMode = int'(mode); mFirst = int'(firstP); mLast = int'(lastP); mDwell = int'(dwell);
        mRun = 1; mK = 0; mAge = 0; mProfile = mFirst; mStep = 1; mSweep = 1; mErr = 0;
      end else begin
        if (start) mErr = 1;
        if (mRun != 0 && enable) begin
          mAge++;
          if (mAge > mDwell) begin
            mAge = 0;
            mK++;
            mN = mLast - mFirst + 1;
            if (mMode == 2 && mK >= mN) begin
              mDone = 1;
              mRun = 0;
            end else begin
              mProfile = profAt(mMode, mFirst, mLast, mK);
              mStep = 1;
              mSweep = (mProfile == mFirst) ? 1 : 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model profile_o", int'(profile_o), mProfile);
    checkOutput("model gpio_o", int'(gpio_o), (mProfile * 512) & 16383);
    checkOutput("model step_o", int'(step_o), mStep);
    checkOutput("model sweep_start_o", int'(sweep_start_o), mSweep);
    checkOutput("model busy_o", int'(busy_o), mRun);
    checkOutput("model done_o", int'(done_o), mDone);
    checkOutput("model err_o", int'(err_o), mErr);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int m, input int f, input int l, input int d);
    mode = 2'(m); firstP = 3'(f); lastP = 3'(l); dwell = 24'(d);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int exp2[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int exp3[6] = '{1, 1, 2, 2, 3, 3};

  initial begin
    reset = 1'b0; enable = 1'b1; mode = '0; firstP = '0; lastP = '0;
    dwell = '0; start = 1'b0; abort = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    checkOutput("reset profile_o", int'(profile_o), 0);
    checkOutput("reset busy_o", int'(busy_o), 0);

    // Free-run 2..5, dwell 3
    applyStimulus(0, 2, 5, 3);
    checkOutput("free first profile", int'(profile_o), 2);
    checkOutput("free first gpio", int'(gpio_o), 1024);
    checkOutput("free first sweep", int'(sweep_start_o), 1);
    tick(4);
    checkOutput("free second profile", int'(profile_o), 3);
    checkOutput("free second gpio", int'(gpio_o), 1536);
    checkOutput("free second step", int'(step_o), 1);
    tick(12);
    checkOutput("free wrap profile", int'(profile_o), 2);
    checkOutput("free wrap sweep", int'(sweep_start_o), 1);

    // Triangle 0..3, dwell 0
    applyStimulus(1, 0, 3, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("tri profile", int'(profile_o), exp2[i]);
      checkOutput("tri sweep", int'(sweep_start_o), (exp2[i] == 0) ? 1 : 0);
      tick(1);
    end

    // Single-shot 1..3, dwell 1
    applyStimulus(2, 1, 3, 1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("single profile", int'(profile_o), exp3[i]);
      checkOutput("single busy", int'(busy_o), 1);
      tick(1);
    end
    checkOutput("single done", int'(done_o), 1);
    checkOutput("single busy at done", int'(busy_o), 0);
    checkOutput("single hold profile", int'(profile_o), 3);
    tick(1);
    checkOutput("single done cleared", int'(done_o), 0);

    // Invalid range then valid start
    applyStimulus(0, 6, 2, 0);
    checkOutput("bad start err", int'(err_o), 1);
    checkOutput("bad start step", int'(step_o), 0);
    checkOutput("bad start busy", int'(busy_o), 0);
    applyStimulus(0, 1, 2, 0);
    checkOutput("good start err", int'(err_o), 0);
    checkOutput("good start busy", int'(busy_o), 1);

    // Pause mid-dwell, then abort+start together
    applyStimulus(0, 0, 7, 5);
    tick(2);
    enable = 1'b0;
    tick(10);
    checkOutput("paused profile", int'(profile_o), 0);
    checkOutput("paused step", int'(step_o), 0);
    enable = 1'b1;
    tick(3);
    checkOutput("resume before step", int'(profile_o), 0);
    tick(1);
    checkOutput("resume step profile", int'(profile_o), 1);
    checkOutput("resume step strobe", int'(step_o), 1);
    mode = 2'd0; firstP = 3'd4; lastP = 3'd6; dwell = 24'd0;
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    checkOutput("abort busy", int'(busy_o), 0);
    checkOutput("abort hold profile", int'(profile_o), 1);
    checkOutput("abort step", int'(step_o), 0);

    // Asynchronous reset mid-sweep
    applyStimulus(0, 1, 4, 0);
    tick(2);
    checkOutput("pre-reset profile", int'(profile_o), 3);
    #2;
    reset = 1'b0;
    #2;
    checkOutput("async reset profile", int'(profile_o), 0);
    checkOutput("async reset gpio", int'(gpio_o), 0);
    checkOutput("async reset busy", int'(busy_o), 0);
    checkOutput("async reset step", int'(step_o), 0);
    tick(3);
    reset = 1'b1;
    tick(5);
    checkOutput("post-reset busy", int'(busy_o), 0);
    checkOutput("post-reset step", int'(step_o), 0);
    checkOutput("post-reset profile", int'(profile_o), 0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      start  = ($urandom_range(0, 19) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if (start) begin
        mode   = 2'($urandom_range(0, 3));
        firstP = 3'($urandom_range(0, 7));
        lastP  = 3'($urandom_range(0, 7));
        dwell  = 24'($urandom_range(0, 4));
      end
      tick(1);
    end
    start = 1'b0; abort = 1'b0; enable = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
